// File: rtl/denorm_pkg.sv
// Shared types and constants for the denormalization pipeline.
package denorm_pkg;

    localparam int PIX_W   = 8;
    localparam int PIX_MAX = 255;
    localparam int SCALE_W = 16;
    localparam int OFF_W   = 10;
    localparam int CLIP_W  = 16;

    // Configuration update sequencer states.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2
    } cfg_state_e;

    // Scale value that maps a normalized sample onto itself (1.0 in the given Q format).
    function automatic logic [SCALE_W-1:0] identity_scale(input int frac_bits);
        return SCALE_W'(1) << frac_bits;
    endfunction

endpackage

// File: rtl/denorm_round_sat.sv
// Combinational back end: round the scaled product, add the offset and clamp to a pixel.
module denorm_round_sat
    import denorm_pkg::*;
#(
    parameter int PROD_W    = 33,
    parameter int FRAC_BITS = 14
) (
    input  logic signed [PROD_W-1:0] prod_i,
    input  logic signed [OFF_W-1:0]  offset_i,
    output logic        [PIX_W-1:0]  pixel_o,
    output logic                     clip_o
);

    // Two guard bits keep the rounding add and the offset add from overflowing.
    localparam int SW = PROD_W + 2;
    localparam logic signed [SW-1:0] HALF  = SW'(1) << (FRAC_BITS - 1);
    localparam logic signed [SW-1:0] MAX_S = SW'(PIX_MAX);

    logic signed [SW-1:0] prod_ext;
    logic signed [SW-1:0] off_ext;
    logic signed [SW-1:0] rounded;
    logic signed [SW-1:0] sum;

    // Round half up (add half LSB, arithmetic shift), offset, then clamp to 0..PIX_MAX.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
        pixel_o  = '0;
        clip_o   = 1'b0;
        prod_ext = {{2{prod_i[PROD_W-1]}}, prod_i};
        off_ext  = {{(SW-OFF_W){offset_i[OFF_W-1]}}, offset_i};
        rounded  = (prod_ext + HALF) >>> FRAC_BITS;
        sum      = rounded + off_ext;
        if (sum[SW-1]) begin
            clip_o = 1'b1;
        end else if (sum > MAX_S) begin
            pixel_o = PIX_W'(PIX_MAX);
            clip_o  = 1'b1;
        end else begin
            pixel_o = sum[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/denormalization.sv
// Three-stage denormalizer: normalized fixed-point samples back to 8-bit pixels,
// with valid/ready flow control, frame-last marking, clip counting and safe config updates.
module denormalization
    import denorm_pkg::*;
#(
    parameter int NORM_WIDTH   = 15,
    parameter int FRAC_BITS    = 14,
    parameter int FRAME_PIXELS = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [NORM_WIDTH:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic        [PIX_W-1:0]    out_pixel,
    output logic                       out_last,
    input  logic                       cfg_load,
    input  logic        [SCALE_W-1:0]  cfg_scale,
    input  logic signed [OFF_W-1:0]    cfg_offset,
    output logic                       cfg_busy,
    output logic        [CLIP_W-1:0]   clip_cnt,
    input  logic                       clip_clr
);

    localparam int IN_W   = NORM_WIDTH + 1;
    localparam int PROD_W = NORM_WIDTH + 18;
    localparam int CNT_W  = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [SCALE_W-1:0] SCALE_ID = identity_scale(FRAC_BITS);

    cfg_state_e state_q, state_d;

    logic                     s1_valid_q, s2_valid_q, s3_valid_q;
    logic signed [IN_W-1:0]   s1_data_q;
    logic signed [PROD_W-1:0] s2_prod_q;
    logic        [PIX_W-1:0]  s3_pixel_q;
    logic                     s3_clip_q;

    logic        [SCALE_W-1:0] scale_q, shadow_scale_q;
    logic signed [OFF_W-1:0]   offset_q, shadow_offset_q;
    logic        [CNT_W-1:0]   frame_cnt_q;
    logic        [CLIP_W-1:0]  clip_cnt_q;

    logic s1_en, s2_en, s3_en, in_fire, out_fire, pipe_empty;
    logic signed [PROD_W-1:0] mult_a, mult_b, mult;
    logic        [PIX_W-1:0]  rs_pixel;
    logic                     rs_clip;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s3_en      = !s3_valid_q || out_ready;
    assign s2_en      = !s2_valid_q || s3_en;
    assign s1_en      = !s1_valid_q || s2_en;
    assign pipe_empty = !(s1_valid_q || s2_valid_q || s3_valid_q);

    // Gating with reset holds in_ready low while reset is asserted.
    assign in_ready = reset && (state_q == ST_RUN) && s1_en;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s3_valid_q && out_ready;

    assign out_valid = s3_valid_q;
    assign out_pixel = s3_pixel_q;
    assign out_last  = s3_valid_q && (frame_cnt_q == LAST_IDX);
    assign cfg_busy  = (state_q != ST_RUN);
    assign clip_cnt  = clip_cnt_q;

    // Sample sign-extended, scale zero-extended, so the product is a plain signed multiply.
    assign mult_a = {{(PROD_W-IN_W){s1_data_q[IN_W-1]}}, s1_data_q};
    assign mult_b = {{(PROD_W-SCALE_W){1'b0}}, scale_q};
    assign mult   = mult_a * mult_b;

    denorm_round_sat #(
        .PROD_W    (PROD_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .prod_i   (s2_prod_q),
        .offset_i (offset_q),
        .pixel_o  (rs_pixel),
        .clip_o   (rs_clip)
    );

    // Pipeline registers: S1 input, S2 product, S3 clamped pixel and clip flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the data registers are reset as well because out_pixel must read 0 after reset.
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_prod_q  <= '0;
            s3_pixel_q <= '0;
            s3_clip_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every stage sees last cycle's values.
            if (s1_en) begin
                s1_valid_q <= in_fire;
                if (in_fire) s1_data_q <= in_data;
            end
            if (s2_en) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_prod_q <= mult;
            end
            if (s3_en) begin
                s3_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    s3_pixel_q <= rs_pixel;
                    s3_clip_q  <= rs_clip;
                end
            end
        end
    end

    // Config sequencer next state: drain the pipe before swapping scale/offset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (cfg_load)   state_d = ST_DRAIN;
            ST_DRAIN: if (pipe_empty) state_d = ST_APPLY;
            ST_APPLY: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Config state register, shadow capture and active-value update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_RUN;
            scale_q         <= SCALE_ID;
            offset_q        <= '0;
            shadow_scale_q  <= SCALE_ID;
            shadow_offset_q <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_load) begin
                shadow_scale_q  <= cfg_scale;
                shadow_offset_q <= cfg_offset;
            end
            // A load arriving during APPLY is newest, so it goes straight to the active set.
            if (state_q == ST_APPLY) begin
                scale_q  <= cfg_load ? cfg_scale  : shadow_scale_q;
                offset_q <= cfg_load ? cfg_offset : shadow_offset_q;
            end
        end
    end

    // Frame position and saturating clip count, both advanced on the output handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
            clip_cnt_q  <= '0;
        end else begin
            if (out_fire) begin
                frame_cnt_q <= (frame_cnt_q == LAST_IDX) ? '0 : frame_cnt_q + 1'b1;
            end
            if (clip_clr) begin
                clip_cnt_q <= '0;
            end else if (out_fire && s3_clip_q && (clip_cnt_q != '1)) begin
                clip_cnt_q <= clip_cnt_q + 1'b1;
            end
        end
    end

endmodule
